pokey_audio_gen: RTL and testbench
==================================

POKEY_AUDIO_GEN -- requirements
Module: pokey_audio_gen

Interface
REQ-001 Parameter NUM_CH, 4, number of audio channels; even, 2..8.
REQ-002 Parameter VOL_W, 4, volume field width per channel.
REQ-003 Parameter ADDR_W, 4, register address width; 2^ADDR_W SHALL be at least 2*NUM_CH+1.
REQ-004 o2  input  1  phase-2 system clock; all state changes on rising edge. One clock only.
REQ-005 rst_L  input  1  reset, asynchronous, active-low.
REQ-006 wr_en  input  1  register write strobe, sampled on o2.
REQ-007 addr  input  ADDR_W  register address.
REQ-008 data_in  input  8  write data.
REQ-009 tick_base  input  1  one-cycle base-rate enable pulse from the external prescaler.
REQ-010 ch_out  output  NUM_CH  per-channel tone bit, after join masking.
REQ-011 audio_out  output  VOL_W+$clog2(NUM_CH)  registered mixed audio sum.

Function
REQ-012 Register map: addr 2k = AUDF[k] (8 bits); addr 2k+1 = AUDC[k]; addr 2*NUM_CH = AUDCTL; writes to other addresses SHALL be ignored.
REQ-013 AUDC[k] fields: [VOL_W-1:0] volume; bit 4 volume-only; bit 5 distortion select (1 = pure tone, 0 = poly noise); other bits stored, unused.
REQ-014 AUDCTL fields: bit j (j < NUM_CH/2) joins pair (2j, 2j+1) into one 16-bit divider; bit 7 fast clock (1 = channels enabled every o2 cycle, 0 = only on tick_base).
REQ-015 Channel enable: en = AUDCTL[7] ? 1 : tick_base.
REQ-016 Unjoined channel: 8-bit down-counter; on en with count = 0, reload AUDF[k] and fire underflow; otherwise decrement. Half-period = AUDF+1 enables.
REQ-017 Joined pair: 16-bit counter, reload value {AUDF[2j+1], AUDF[2j]}; underflow is attributed to channel 2j+1; channel 2j ch_out bit SHALL be 0 and its volume SHALL be excluded from the mix.
REQ-018 On underflow: pure tone toggles the channel output flop; poly noise loads poly[0] into it.
REQ-019 poly: 17-bit LFSR, shifts every o2 cycle regardless of en; new bit = poly[16] XOR poly[11], shifted into bit 0.
REQ-020 AUDF writes SHALL not disturb the running count; the new value is used at the next reload. Write and reload on the same edge SHALL reload the old value.
REQ-021 AUDC writes SHALL take effect from the next cycle onward.
REQ-022 Any AUDCTL write SHALL, on the same edge, load every counter with its current reload value and clear all output flops.
REQ-023 Channel contribution = volume if volume-only = 1; else volume if output flop = 1; else 0.
REQ-024 audio_out = sum of contributions of unmasked channels, registered: latency 1 cycle from flop/register change. No saturation; width covers the maximum.
REQ-025 ch_out = output flops AND NOT join mask, combinational from flops.

Reset
REQ-026 While rst_L = 0: all AUDF, AUDC, AUDCTL = 0; counters = 0; output flops = 0; ch_out = 0; audio_out = 0; poly = 17'h1FFFF.
REQ-027 Reset assertion mid-operation SHALL clear state immediately, without waiting for o2; operation resumes on the first o2 edge after deassertion.

Verification
REQ-028 AUDCTL = 8'h80, AUDF[0] = 3, AUDC[0] = 8'h2F -> ch_out[0] toggles every 4 cycles; audio_out alternates 0/15 with 1-cycle lag.
REQ-029 AUDCTL = 8'h81, AUDF[0] = 8'h00, AUDF[1] = 8'h01, AUDC[1] = 8'h25 -> ch_out[1] toggles every 257 cycles; ch_out[0] = 0 throughout; AUDC[0] volume is excluded from audio_out.
REQ-030 All four AUDC = 8'h1F (volume-only), NUM_CH = 4 -> audio_out = 60 one cycle after the last write.
REQ-031 AUDCTL = 0, AUDF[2] = 1, tick_base pulsed every 5 cycles -> ch_out[2] toggles every 2 ticks. Rewrite AUDF[2] = 4 mid-count -> old period finishes, new period starts at the reload.
REQ-032 AUDC[0] = 8'h0F (poly), fast clock -> ch_out[0] matches the reference LFSR bit at each underflow. Pulse rst_L low between edges -> outputs cleared asynchronously, poly = 1FFFF.

Source files
------------

// File: rtl/pokey_audio_gen.sv
// POKEY-style audio generator: per-channel programmable dividers with optional
// 16-bit pair joining, pure-tone / 17-bit poly-noise output, and a registered mix.
//
// Handshake: the register port is a plain write strobe. When wr_en is high on a
// rising o2 edge, data_in is written to addr. There is no ready and no back-pressure.
// Writes to unmapped addresses have no effect.
module pokey_audio_gen #(
    parameter int NUM_CH = 4,
    parameter int VOL_W  = 4,
    parameter int ADDR_W = 4
) (
    input  logic                             o2,
    input  logic                             rst_L,
    input  logic                             wr_en,
    input  logic [ADDR_W-1:0]                addr,
    input  logic [7:0]                       data_in,
    input  logic                             tick_base,
    output logic [NUM_CH-1:0]                ch_out,
    output logic [VOL_W+$clog2(NUM_CH)-1:0]  audio_out
);
    localparam int AW = VOL_W + $clog2(NUM_CH);
    localparam int NP = NUM_CH / 2;
    localparam logic [ADDR_W-1:0] CTL_ADDR = ADDR_W'(2 * NUM_CH);

    logic [7:0]        audf    [NUM_CH];
    logic [7:0]        audc    [NUM_CH];
    logic [7:0]        cnt     [NUM_CH];
    logic [7:0]        cnt_nxt [NUM_CH];
    logic [7:0]        audctl;
    logic [NUM_CH-1:0] flop;
    logic [NUM_CH-1:0] uf;
    logic [NUM_CH-1:0] join_mask;
    logic [16:0]       poly;
    logic [AW-1:0]     mix;
    logic              en;
    logic              ctl_wr;

    assign en     = audctl[7] | tick_base;
    assign ctl_wr = wr_en && (addr == CTL_ADDR);
    assign ch_out = flop & ~join_mask;

    // The low channel of every joined pair is silenced and kept out of the mix.
    always_comb begin
        join_mask = '0;
        for (int j = 0; j < NP; j++) begin
            join_mask[2*j] = audctl[j];
        end
    end

    // Divider next state. A joined pair counts as one 16-bit value whose underflow belongs to the high channel.
    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            cnt_nxt[k] = cnt[k];
            uf[k]      = 1'b0;
        end
        if (en) begin
            for (int j = 0; j < NP; j++) begin
                if (audctl[j]) begin
                    if ({cnt[2*j+1], cnt[2*j]} == 16'd0) begin
                        cnt_nxt[2*j+1] = audf[2*j+1];
                        cnt_nxt[2*j]   = audf[2*j];
                        uf[2*j+1]      = 1'b1;
                    end else begin
                        {cnt_nxt[2*j+1], cnt_nxt[2*j]} = {cnt[2*j+1], cnt[2*j]} - 16'd1;
                    end
                end else begin
                    for (int h = 0; h < 2; h++) begin
                        if (cnt[2*j+h] == 8'd0) begin
                            cnt_nxt[2*j+h] = audf[2*j+h];
                            uf[2*j+h]      = 1'b1;
                        end else begin
                            cnt_nxt[2*j+h] = cnt[2*j+h] - 8'd1;
                        end
                    end
                end
            end
        end
    end

    // Mix: a channel contributes its volume when it is volume-only or when its output flop is high.
    always_comb begin
        mix = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!join_mask[k] && (audc[k][4] || flop[k])) begin
                mix = mix + AW'(audc[k][VOL_W-1:0]);
            end
        end
    end

    // Register file. The new AUDF value only reaches the counter at its next reload.
    always_ff @(posedge o2 or negedge rst_L) begin
        if (!rst_L) begin
            for (int k = 0; k < NUM_CH; k++) begin
                audf[k] <= '0;
                audc[k] <= '0;
            end
            audctl <= '0;
        end else if (wr_en) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (addr == ADDR_W'(2*k))     audf[k] <= data_in;
                if (addr == ADDR_W'(2*k + 1)) audc[k] <= data_in;
            end
            if (ctl_wr) audctl <= data_in;
        end
    end

    // Counters and output flops. An AUDCTL write restarts every divider from its current AUDF and clears all outputs.
    always_ff @(posedge o2 or negedge rst_L) begin
        if (!rst_L) begin
            for (int k = 0; k < NUM_CH; k++) begin
                cnt[k] <= '0;
            end
            flop <= '0;
        end else if (ctl_wr) begin
            for (int k = 0; k < NUM_CH; k++) begin
                cnt[k] <= audf[k];
            end
            flop <= '0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                cnt[k] <= cnt_nxt[k];
                if (uf[k]) flop[k] <= audc[k][5] ? ~flop[k] : poly[0];
            end
        end
    end

    // The poly counter free-runs on every o2 cycle, and the mix is registered one cycle behind.
    always_ff @(posedge o2 or negedge rst_L) begin
        if (!rst_L) begin
            poly      <= 17'h1FFFF;
            audio_out <= '0;
        end else begin
            poly      <= {poly[15:0], poly[16] ^ poly[11]};
            audio_out <= mix;
        end
    end

endmodule

// File: tb/tb_pokey_audio_gen.sv
// Directed bench for pokey_audio_gen: fast-clock tone table, volume-only mix,
// joined 16-bit pair, tick-driven divider with AUDF rewrites, poly noise, async reset.
module tb_pokey_audio_gen;

    logic       o2        = 1'b0;
    logic       rst_L     = 1'b0;
    logic       wr_en     = 1'b0;
    logic [3:0] addr      = '0;
    logic [7:0] data_in   = '0;
    logic       tick_base = 1'b0;
    logic [3:0] ch_out;
    logic [5:0] audio_out;

    int n_cmp = 0;
    int n_err = 0;

    // Reference poly counter. It is reset with the DUT and shifted once per o2 edge.
    logic [16:0] ref_poly = 17'h1FFFF;
    logic        ref_bit  = 1'b0;
    logic [5:0]  exp_q[$];

    typedef struct packed {
        logic       wr;
        logic [3:0] a;
        logic [7:0] d;
        logic [3:0] ch_mask;
        logic [3:0] ch_exp;
        logic [5:0] aud_exp;
    } vec_t;

    vec_t vecs [19];

    pokey_audio_gen #(.NUM_CH(4), .VOL_W(4), .ADDR_W(4)) dut (
        .o2        (o2),
        .rst_L     (rst_L),
        .wr_en     (wr_en),
        .addr      (addr),
        .data_in   (data_in),
        .tick_base (tick_base),
        .ch_out    (ch_out),
        .audio_out (audio_out)
    );

    // Clock.
    always #5 o2 = ~o2;

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One o2 cycle: inputs are driven on the falling edge, and the call returns 1 time unit after the rising edge.
    task automatic cyc(input logic w, input logic [3:0] a, input logic [7:0] d, input logic t);
        @(negedge o2);
        wr_en     = w;
        addr      = a;
        data_in   = d;
        tick_base = t;
        @(posedge o2);
        ref_bit  = ref_poly[0];
        ref_poly = {ref_poly[15:0], ref_poly[16] ^ ref_poly[11]};
        #1;
        wr_en     = 1'b0;
        tick_base = 1'b0;
    endtask

    // Asserts reset between clock edges and checks that the outputs clear without a clock edge.
    task automatic pulse_reset(input string tag);
        #2 rst_L = 1'b0;
        #1;
        check({tag, " async ch_out"}, 32'(ch_out), 32'd0);
        check({tag, " async audio"}, 32'(audio_out), 32'd0);
        cyc(1'b1, 4'd8, 8'h80, 1'b0);
        cyc(1'b0, 4'd0, 8'h00, 1'b0);
        check({tag, " held ch_out"}, 32'(ch_out), 32'd0);
        check({tag, " held audio"}, 32'(audio_out), 32'd0);
        #2 rst_L = 1'b1;
        ref_poly = 17'h1FFFF;
    endtask

    // Poly noise on channel 0 with fast clock. Channel 0 underflows every cycle, so it follows the reference poly bit.
    task automatic poly_run(input string tag);
        logic exp_bit;
        cyc(1'b1, 4'd1, 8'h0F, 1'b0);
        cyc(1'b1, 4'd8, 8'h80, 1'b0);
        check($sformatf("%s ch0 after ctl", tag), 32'(ch_out[0]), 32'd0);
        exp_q.delete();
        exp_q.push_back(6'd0);
        for (int n = 1; n <= 40; n++) begin
            cyc(1'b0, 4'd0, 8'h00, 1'b0);
            exp_bit = ref_bit;
            check($sformatf("%s ch0 n%0d", tag, n), 32'(ch_out[0]), 32'(exp_bit));
            check($sformatf("%s audio n%0d", tag, n), 32'(audio_out), 32'(exp_q.pop_front()));
            exp_q.push_back(exp_bit ? 6'd15 : 6'd0);
        end
    endtask

    initial begin
        logic [16:0] exp_flop;
        logic        f;
        logic        pf;

        // Table for the fast-clock pure tone: AUDF0=3, AUDC0=2F, AUDCTL=80.
        vecs[0] = '{wr: 1'b1, a: 4'd0, d: 8'h03, ch_mask: 4'hF, ch_exp: 4'h0, aud_exp: 6'd0};
        vecs[1] = '{wr: 1'b1, a: 4'd1, d: 8'h2F, ch_mask: 4'hF, ch_exp: 4'h0, aud_exp: 6'd0};
        vecs[2] = '{wr: 1'b1, a: 4'd8, d: 8'h80, ch_mask: 4'hF, ch_exp: 4'h0, aud_exp: 6'd0};
        for (int n = 1; n <= 16; n++) begin
            vecs[2+n].wr      = 1'b0;
            vecs[2+n].a       = 4'd0;
            vecs[2+n].d       = 8'h00;
            vecs[2+n].ch_mask = 4'h1;
            vecs[2+n].ch_exp  = (((n / 4) % 2) == 1) ? 4'h1 : 4'h0;
            vecs[2+n].aud_exp = ((((n - 1) / 4) % 2) == 1) ? 6'd15 : 6'd0;
        end

        pulse_reset("rst0");

        for (int i = 0; i < 19; i++) begin
            cyc(vecs[i].wr, vecs[i].a, vecs[i].d, 1'b0);
            check($sformatf("tone ch_out v%0d", i), 32'(ch_out & vecs[i].ch_mask),
                  32'(vecs[i].ch_exp & vecs[i].ch_mask));
            check($sformatf("tone audio v%0d", i), 32'(audio_out), 32'(vecs[i].aud_exp));
        end

        // Volume-only on all four channels; the mix follows each write one cycle later.
        cyc(1'b1, 4'd1, 8'h1F, 1'b0);
        cyc(1'b1, 4'd3, 8'h1F, 1'b0);
        cyc(1'b1, 4'd5, 8'h1F, 1'b0);
        cyc(1'b1, 4'd7, 8'h1F, 1'b0);
        check("volonly audio at last write", 32'(audio_out), 32'd45);
        cyc(1'b0, 4'd0, 8'h00, 1'b0);
        check("volonly audio", 32'(audio_out), 32'd60);
        cyc(1'b1, 4'd15, 8'h00, 1'b0);
        cyc(1'b1, 4'd9, 8'h00, 1'b0);
        cyc(1'b0, 4'd0, 8'h00, 1'b0);
        check("unmapped writes ignored", 32'(audio_out), 32'd60);

        // Joined pair 0/1 with reload 0x0100. AUDC0 keeps volume-only 15, which must stay out of the mix.
        cyc(1'b1, 4'd0, 8'h00, 1'b0);
        cyc(1'b1, 4'd2, 8'h01, 1'b0);
        cyc(1'b1, 4'd3, 8'h25, 1'b0);
        cyc(1'b1, 4'd5, 8'h00, 1'b0);
        cyc(1'b1, 4'd7, 8'h00, 1'b0);
        cyc(1'b1, 4'd8, 8'h81, 1'b0);
        for (int n = 1; n <= 515; n++) begin
            cyc(1'b0, 4'd0, 8'h00, 1'b0);
            f  = (n >= 257) && (n <= 513);
            pf = (n >= 258) && (n <= 514);
            check($sformatf("join ch_out[1:0] n%0d", n), 32'(ch_out[1:0]), f ? 32'd2 : 32'd0);
            check($sformatf("join audio n%0d", n), 32'(audio_out), pf ? 32'd5 : 32'd0);
        end

        // Tick-driven channel 2, AUDF2=1, with a tick every 5 cycles. AUDF2 is rewritten to 4 before tick 3,
        // and to 1 on the reloading edge of tick 9. The output toggles at ticks 2, 4, 9, 14 and 16.
        cyc(1'b1, 4'd1, 8'h00, 1'b0);
        cyc(1'b1, 4'd3, 8'h00, 1'b0);
        cyc(1'b1, 4'd7, 8'h00, 1'b0);
        cyc(1'b1, 4'd4, 8'h01, 1'b0);
        cyc(1'b1, 4'd5, 8'h23, 1'b0);
        cyc(1'b1, 4'd8, 8'h00, 1'b0);
        exp_flop = 17'h13E0C;
        for (int t = 1; t <= 16; t++) begin
            for (int i = 0; i < 4; i++) begin
                cyc((t == 3) && (i == 1), 4'd4, 8'h04, 1'b0);
                if (i == 0) begin
                    check($sformatf("tick audio t%0d", t), 32'(audio_out),
                          exp_flop[t-1] ? 32'd3 : 32'd0);
                end
                if (i == 3) begin
                    check($sformatf("tick hold ch2 t%0d", t), 32'(ch_out[2]), 32'(exp_flop[t-1]));
                end
            end
            cyc(t == 9, 4'd4, 8'h01, 1'b1);
            check($sformatf("tick ch2 t%0d", t), 32'(ch_out[2]), 32'(exp_flop[t]));
        end
        cyc(1'b0, 4'd0, 8'h00, 1'b0);
        check("tick audio final", 32'(audio_out), 32'd3);

        pulse_reset("rst1");
        poly_run("poly1");
        pulse_reset("rst2");
        poly_run("poly2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
